display_buffer_ctrl: RTL and testbench

DISPLAY_BUFFER_CTRL -- requirements
Module: display_buffer_ctrl

---
 rtl/display_buffer_ctrl.sv | 179 +++++++++++++++++
 tb/tb_display_buffer_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_buffer_ctrl.sv
// display_buffer_ctrl
//
// Purpose: collects 4-bit display symbols from a producer into a small FIFO
// and commits them to a packed symbol buffer only during vertical blanking,
// so the display never sees a half-updated buffer in the middle of a frame.
// A pending clear blanks the whole buffer before the next burst.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        synchronous, active-high reset
//   sym_valid    producer offers sym_code this cycle
//   sym_code     symbol: 0-9 digits, a '+', b '-', c '*', d '/', e '=', f blank
//   sym_ready    FIFO not full (forced low while reset is high)
//   clr_req      single-cycle request to blank the whole buffer
//   frame_start  single-cycle pulse at the start of vertical blanking
//   numbers      committed buffer, slot k at bits [4k+3:4k]
//   busy         high while clearing or committing (forced low during reset)
//   overflow     sticky: a write landed in the last slot and the cursor wrapped
//
// Optional feature macro: DISP_CLEAR_ON_WRAP_EN
//   When defined, a write that wraps the cursor also blanks slots 1..last.

module display_buffer_ctrl #(
    parameter int maxInput   = 384,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sym_valid,
    input  logic [3:0]          sym_code,
    output logic                sym_ready,
    input  logic                clr_req,
    input  logic                frame_start,
    output logic [maxInput-1:0] numbers,
    output logic                busy,
    output logic                overflow
);

    localparam int SLOTS = maxInput / 4;
    localparam int CW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CLEAR  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam logic [CW-1:0] LAST_SLOT = CW'(SLOTS - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

    logic [1:0]          state_q,     state_d;
    logic [maxInput-1:0] numbers_q,   numbers_d;
    logic [CW-1:0]       cursor_q,    cursor_d;
    logic [AW:0]         burst_cnt_q, burst_cnt_d;
    logic                clr_pend_q,  clr_pend_d;
    logic                overflow_q,  overflow_d;
    logic [AW-1:0]       wr_ptr_q,    wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q,    rd_ptr_d;
    logic [AW:0]         count_q,     count_d;
    logic [3:0]          mem_q [FIFO_DEPTH];
    logic [3:0]          mem_d [FIFO_DEPTH];

    logic push;
    logic pop;

    assign sym_ready = !reset && (count_q != FULL_CNT);
    assign busy      = !reset && (state_q != ST_IDLE);
    assign numbers   = numbers_q;
    assign overflow  = overflow_q;

    // COMMIT is only entered with a nonzero burst, and the FIFO always holds
    // at least burst_cnt entries, so every COMMIT cycle can pop safely.
    assign push = sym_valid && sym_ready;
    assign pop  = (state_q == ST_COMMIT);

    // FIFO bookkeeping: a push and a pop may share a cycle; the pushed symbol
    // lands behind the burst and waits for the next frame.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = sym_code;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
    end

    // Frame sequencer: the buffer only changes in CLEAR or COMMIT, both of
    // which are entered from IDLE on frame_start.
    always_comb begin
        state_d     = state_q;
        numbers_d   = numbers_q;
        cursor_d    = cursor_q;
        burst_cnt_d = burst_cnt_q;
        clr_pend_d  = clr_pend_q | clr_req;
        overflow_d  = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    burst_cnt_d = count_q;
                    // A clr_req in the same cycle as frame_start clears now.
                    if (clr_pend_q || clr_req) begin
                        state_d = ST_CLEAR;
                    end else if (count_q != '0) begin
                        state_d = ST_COMMIT;
                    end
                end
            end

            ST_CLEAR: begin
                numbers_d  = '1;
                cursor_d   = '0;
                // Only a request arriving during CLEAR survives to next frame.
                clr_pend_d = clr_req;
                state_d    = (burst_cnt_q != '0) ? ST_COMMIT : ST_IDLE;
            end

            ST_COMMIT: begin
                numbers_d[int'(cursor_q)*4 +: 4] = mem_q[rd_ptr_q];
                burst_cnt_d = burst_cnt_q - (AW + 1)'(1);
                if (cursor_q == LAST_SLOT) begin
                    cursor_d   = '0;
                    overflow_d = 1'b1;
`ifdef DISP_CLEAR_ON_WRAP_EN
                    // Slot 0 keeps its old symbol; the just-written last
                    // slot is blanked along with the rest.
                    for (int k = 1; k < SLOTS; k++) begin
                        numbers_d[k*4 +: 4] = 4'hf;
                    end
`endif
                end else begin
                    cursor_d = cursor_q + CW'(1);
                end
                if (burst_cnt_q == (AW + 1)'(1)) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            numbers_q   <= '1;
            cursor_q    <= '0;
            burst_cnt_q <= '0;
            clr_pend_q  <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            numbers_q   <= numbers_d;
            cursor_q    <= cursor_d;
            burst_cnt_q <= burst_cnt_d;
            clr_pend_q  <= clr_pend_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage needs no reset: emptiness is tracked by count_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_display_buffer_ctrl.sv
// tb_display_buffer_ctrl
//
// Purpose: randomized plus directed stimulus for display_buffer_ctrl. A
// behavioural model of the buffer predicts, at each frame_start, every buffer
// snapshot of the coming burst and queues it with the clock edge it belongs
// to; an independent monitor pops one expectation for each busy cycle and
// checks numbers/overflow, and checks that the buffer holds still otherwise.

module tb_display_buffer_ctrl;

    localparam int MAXIN = 384;
    localparam int DEPTH = 8;
    localparam int SLOTS = MAXIN / 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             sym_valid = 1'b0;
    logic [3:0]       sym_code = 4'h0;
    logic             sym_ready;
    logic             clr_req = 1'b0;
    logic             frame_start = 1'b0;
    logic [MAXIN-1:0] numbers;
    logic             busy;
    logic             overflow;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    typedef struct {
        int               edge_no;
        logic [MAXIN-1:0] nums;
        logic             ovf;
    } exp_t;

    exp_t       sbq[$];
    logic [3:0] mq[$];
    int         pop_edges[$];
    logic [3:0] m_buf[SLOTS];
    int         m_cursor = 0;
    bit         m_ovf = 1'b0;
    bit         m_pend = 1'b0;
    int         m_last_busy = 0;

    display_buffer_ctrl #(.maxInput(MAXIN), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .sym_valid(sym_valid), .sym_code(sym_code),
        .sym_ready(sym_ready), .clr_req(clr_req), .frame_start(frame_start),
        .numbers(numbers), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check_vec(input string name, input logic [MAXIN-1:0] act, input logic [MAXIN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [MAXIN-1:0] pack_buf();
        logic [MAXIN-1:0] v;
        for (int k = 0; k < SLOTS; k++) v[k*4 +: 4] = m_buf[k];
        return v;
    endfunction

    // Behavioural model: decide everything the coming frame will do at once.
    task automatic model_edge(input int e, input bit acc, input logic [3:0] code,
                              input bit clr, input bit fs, input bit rst);
        int t;
        int n;
        if (rst) begin
            mq.delete();
            pop_edges.delete();
            for (int k = 0; k < SLOTS; k++) m_buf[k] = 4'hf;
            m_cursor = 0;
            m_ovf = 1'b0;
            m_pend = 1'b0;
            m_last_busy = 0;
            while (sbq.size() > 0 && sbq[$].edge_no >= e) void'(sbq.pop_back());
            return;
        end
        if (fs && e > m_last_busy) begin
            n = mq.size();
            t = e + 1;
            if (m_pend || clr) begin
                for (int k = 0; k < SLOTS; k++) m_buf[k] = 4'hf;
                m_cursor = 0;
                m_pend = 1'b0;
                sbq.push_back('{t, pack_buf(), m_ovf});
                t++;
            end
            for (int i = 0; i < n; i++) begin
                m_buf[m_cursor] = mq.pop_front();
                if (m_cursor == SLOTS - 1) begin
                    m_cursor = 0;
                    m_ovf = 1'b1;
`ifdef DISP_CLEAR_ON_WRAP_EN
                    for (int k = 1; k < SLOTS; k++) m_buf[k] = 4'hf;
`endif
                end else begin
                    m_cursor++;
                end
                sbq.push_back('{t, pack_buf(), m_ovf});
                pop_edges.push_back(t);
                t++;
            end
            m_last_busy = t - 1;
        end else if (clr) begin
            m_pend = 1'b1;
        end
        if (acc) mq.push_back(code);
    endtask

    // Drive one cycle's inputs, check handshake/busy, and advance the model.
    task automatic applyStimulus(input bit v, input logic [3:0] code, input bit clr,
                                 input bit fs, input bit rst, output bit acc);
        int e;
        bit exp_ready;
        bit exp_busy;
        @(posedge clk);
        #1;
        e = edge_n + 1;
        sym_valid = v;
        sym_code = code;
        clr_req = clr;
        frame_start = fs;
        reset = rst;
        #1;
        while (pop_edges.size() > 0 && pop_edges[0] < e) void'(pop_edges.pop_front());
        exp_ready = !rst && (mq.size() + pop_edges.size() < DEPTH);
        exp_busy = !rst && (e <= m_last_busy);
        check_int("sym_ready", int'(sym_ready), int'(exp_ready));
        check_int("busy", int'(busy), int'(exp_busy));
        acc = v && sym_ready;
        model_edge(e, acc, code, clr, fs, rst);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, acc);
    endtask

    task automatic push_sym(input logic [3:0] code);
        bit acc;
        int tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 50) begin
            applyStimulus(1'b1, code, 1'b0, 1'b0, 1'b0, acc);
            tries++;
        end
        if (!acc) check_int("push_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (edge_n + 1 <= m_last_busy && i < 300) begin
            idle(1);
            i++;
        end
        if (edge_n + 1 <= m_last_busy) check_int("idle_timeout", 0, 1);
    endtask

    task automatic pulse(input bit clr, input bit fs);
        bit acc;
        applyStimulus(1'b0, 4'h0, clr, fs, 1'b0, acc);
    endtask

    // Monitor: every busy cycle ends in one buffer update to compare.
    task automatic checkOutput(input bit prev_busy, inout logic [MAXIN-1:0] last_nums, inout logic last_ovf);
        exp_t it;
        if (prev_busy) begin
            if (sbq.size() == 0) begin
                check_int("sb_underflow", 1, 0);
            end else begin
                it = sbq.pop_front();
                check_int("commit_edge", edge_n, it.edge_no);
                check_vec("numbers", numbers, it.nums);
                check_int("overflow", int'(overflow), int'(it.ovf));
                last_nums = it.nums;
                last_ovf = it.ovf;
            end
        end else begin
            check_vec("numbers_hold", numbers, last_nums);
            check_int("overflow_hold", int'(overflow), int'(last_ovf));
        end
    endtask

    initial begin
        bit               prev_busy;
        logic [MAXIN-1:0] last_nums;
        logic             last_ovf;
        prev_busy = 1'b0;
        last_nums = '1;
        last_ovf = 1'b0;
        forever begin
            @(negedge clk);
            if (edge_n >= 1) begin
                checkOutput(prev_busy, last_nums, last_ovf);
                if (reset) begin
                    last_nums = '1;
                    last_ovf = 1'b0;
                    prev_busy = 1'b0;
                end else begin
                    prev_busy = busy;
                end
            end
        end
    end

    initial begin
        bit acc;
        for (int k = 0; k < SLOTS; k++) m_buf[k] = 4'hf;

        // Reset for two cycles, then three symbols held back for 100 cycles.
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, acc);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, acc);
        push_sym(4'h1);
        push_sym(4'h2);
        push_sym(4'h3);
        idle(100);
        pulse(1'b0, 1'b1);
        wait_idle();
        idle(3);

        // Nine symbols into an eight-deep FIFO.
        for (int i = 0; i < 8; i++) push_sym(4'(i + 1));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'h9, 1'b0, 1'b0, 1'b0, acc);
            check_int("ninth_held", int'(acc), 0);
        end
        applyStimulus(1'b1, 4'h9, 1'b0, 1'b1, 1'b0, acc);
        if (!acc) push_sym(4'h9);
        wait_idle();
        pulse(1'b0, 1'b1);
        wait_idle();
        idle(2);

        // "12+3" then clear with 4,5 queued.
        push_sym(4'h1);
        push_sym(4'h2);
        push_sym(4'ha);
        push_sym(4'h3);
        pulse(1'b0, 1'b1);
        wait_idle();
        pulse(1'b1, 1'b0);
        push_sym(4'h4);
        push_sym(4'h5);
        pulse(1'b0, 1'b1);
        wait_idle();
        push_sym(4'he);
        pulse(1'b1, 1'b1);
        wait_idle();

        // Fill all slots with 7 from cursor 0, then one more symbol wraps.
        pulse(1'b1, 1'b1);
        wait_idle();
        for (int f = 0; f < SLOTS / DEPTH; f++) begin
            for (int i = 0; i < DEPTH; i++) push_sym(4'h7);
            pulse(1'b0, 1'b1);
            wait_idle();
        end
        push_sym(4'h0);
        pulse(1'b0, 1'b1);
        wait_idle();
        idle(2);

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 6, 1'b0, acc);
        end
        pulse(1'b0, 1'b1);
        wait_idle();

        // Reset after two writes of a five-symbol burst.
        for (int i = 0; i < 5; i++) push_sym(4'(i + 2));
        pulse(1'b0, 1'b1);
        idle(2);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, acc);
        idle(1);
        check_vec("reset_numbers", numbers, '1);
        check_int("reset_overflow", int'(overflow), 0);
        idle(2);
        push_sym(4'hc);
        pulse(1'b0, 1'b1);
        wait_idle();
        idle(3);

        check_int("sb_drain", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
